fib_seq_monitor: RTL

// - Parametrised successor to our 8-bit additive-sequence test design.
// - Generates x' = x + y, y' = x while x < LIMIT, then freezes x.
// - Adds step enable, restart, a RUN/HOLD/DONE FSM, overflow detection and a step counter.
// - Provides threshold flags for property checking.
// - Sits in the model-checking test suite as a configurable reachability/invariant target.

---
 rtl/fib_seq_monitor_if.sv | 27 ++
 rtl/fib_seq_monitor.sv | 90 +++++++++
 2 files changed

// File: rtl/fib_seq_monitor_if.sv
// Control and observation bundle for fib_seq_monitor: the step/restart inputs
// plus the x/y registers, threshold flags, overflow, done and step count.
interface fib_seq_monitor_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             restart;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             lo_ge;
    logic             hi_gt;
    logic             hi_eq;
    logic             ovf;
    logic             done;
    logic [CNT_W-1:0] steps;

    modport master (
        output en, restart,
        input  x, y, lo_ge, hi_gt, hi_eq, ovf, done, steps
    );

    modport slave (
        input  en, restart,
        output x, y, lo_ge, hi_gt, hi_eq, ovf, done, steps
    );
endinterface

// File: rtl/fib_seq_monitor.sv
// Additive-sequence generator (x' = x + y, y' = x) with RUN/HOLD/DONE FSM,
// sticky overflow and saturating step counter. Define FIB_SAT_ADD_EN to
// saturate x on carry-out instead of wrapping.
module fib_seq_monitor #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned INIT_X = 1,
    parameter int unsigned INIT_Y = 1,
    parameter int unsigned LIMIT  = 100,
    parameter int unsigned HI     = 200,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    fib_seq_monitor_if.slave  bus
);
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] INIT_X_W = INIT_X[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INIT_Y_W = INIT_Y[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LIMIT_W  = LIMIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] HI_W     = HI[WIDTH-1:0];
    localparam state_t           INIT_ST  = (INIT_X_W < LIMIT_W) ? S_RUN : S_HOLD;

    state_t           state_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             ovf_q;
    logic [CNT_W-1:0] steps_q;

    logic [WIDTH:0]   sum;
    logic             carry;
    logic [WIDTH-1:0] x_d;
    logic [CNT_W-1:0] steps_d;

    always_comb begin
        sum   = {1'b0, x_q} + {1'b0, y_q};
        carry = sum[WIDTH];
`ifdef FIB_SAT_ADD_EN
        x_d   = carry ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        x_d   = sum[WIDTH-1:0];
`endif
        steps_d = (steps_q == {CNT_W{1'b1}}) ? steps_q : steps_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset || bus.restart) begin
            x_q     <= INIT_X_W;
            y_q     <= INIT_Y_W;
            ovf_q   <= 1'b0;
            steps_q <= '0;
            state_q <= INIT_ST;
        end else if (bus.en) begin
            case (state_q)
                S_RUN: begin
                    if (x_q < LIMIT_W) begin
                        x_q     <= x_d;
                        y_q     <= x_q;
                        ovf_q   <= ovf_q | carry;
                        steps_q <= steps_d;
                        // Decision is taken on the value x will actually hold (post-wrap/saturate)
                        state_q <= (x_d < LIMIT_W) ? S_RUN : S_HOLD;
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    y_q     <= x_q;
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_DONE;
                end
            endcase
        end
    end

    assign bus.x     = x_q;
    assign bus.y     = y_q;
    assign bus.lo_ge = (x_q >= LIMIT_W);
    assign bus.hi_gt = (x_q > HI_W);
    assign bus.hi_eq = (x_q == HI_W) || (y_q == HI_W);
    assign bus.ovf   = ovf_q;
    assign bus.done  = (state_q == S_DONE);
    assign bus.steps = steps_q;
endmodule
